// File: rtl/wb_arbiter_pkg.sv
// Shared widths and types for the write-back arbiter: register-file bus widths,
// the largest supported requester count and the per-slot payload record.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int WB_REQ_MAX = 8;

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;
    localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Next round-robin index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus between the requesters and the arbiter, plus the register-file
// write port it drives. Requester fields are packed flat, requester i at slice i.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*REG_DATA_W-1:0] req_data;
    logic                          w_enable;
    logic [REG_ADDR_W-1:0]         w_addr;
    logic [REG_DATA_W-1:0]         w_data;
    logic                          busy;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, w_enable, w_addr, w_data, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, w_enable, w_addr, w_data, busy
    );
endinterface

// File: rtl/wb_slot.sv
// One-entry write-back buffer. Push wins over pop so a slot refills in the same
// cycle it drains; callers qualify push/pop with the global ready.
module wb_slot
    import wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [REG_ADDR_W-1:0] push_addr,
    input  logic [REG_DATA_W-1:0] push_data,
    output logic                  full,
    output logic [REG_ADDR_W-1:0] addr,
    output logic [REG_DATA_W-1:0] data
);

    wb_req_t entry_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    // Payload carries no reset; it is only observed while full is set.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_p0 <= '{addr: push_addr, data: push_data};
        end
    end

    assign addr = entry_p0.addr;
    assign data = entry_p0.data;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    wb_arbiter_if.slave  wb
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    full;
    logic [NUM_REQ-1:0]    push;
    logic [NUM_REQ-1:0]    grant_p0;
    logic [IDX_W-1:0]      gidx_p0;
    logic                  vld_p0;
    logic [REG_ADDR_W-1:0] slot_addr [NUM_REQ];
    logic [REG_DATA_W-1:0] slot_data [NUM_REQ];
    logic [REG_ADDR_W-1:0] sel_addr_p0;
    logic [REG_DATA_W-1:0] sel_data_p0;

    logic                  vld_p1;
    logic [REG_ADDR_W-1:0] w_addr_p1;
    logic [REG_DATA_W-1:0] w_data_p1;

    // Stage 0: requester slots and handshake
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign wb.req_ready[i] = rdy & ~rst & (~full[i] | grant_p0[i]);
        assign push[i]         = wb.req_valid[i] & wb.req_ready[i];

        wb_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .pop       (grant_p0[i]),
            .push_addr (wb.req_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .push_data (wb.req_data[i*REG_DATA_W +: REG_DATA_W]),
            .full      (full[i]),
            .addr      (slot_addr[i]),
            .data      (slot_data[i])
        );
    end

`ifdef WB_ARB_RR_EN
    logic [IDX_W-1:0] ptr;

    always_comb begin
        grant_p0 = '0;
        gidx_p0  = '0;
        vld_p0   = 1'b0;
        if (rdy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!vld_p0 && full[idx]) begin
                    grant_p0[idx] = 1'b1;
                    gidx_p0       = IDX_W'(idx);
                    vld_p0        = 1'b1;
                end
            end
        end
    end

    // Priority moves just past the slot that won; it stays put on idle or stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (vld_p0) begin
            ptr <= IDX_W'(wrap_inc(int'(gidx_p0), NUM_REQ));
        end
    end
`else
    always_comb begin
        grant_p0 = '0;
        gidx_p0  = '0;
        vld_p0   = 1'b0;
        if (rdy) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!vld_p0 && full[i]) begin
                    grant_p0[i] = 1'b1;
                    gidx_p0     = IDX_W'(i);
                    vld_p0      = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        sel_addr_p0 = slot_addr[gidx_p0];
        sel_data_p0 = slot_data[gidx_p0];
    end

    // Stage 1: registered register-file write port
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            w_addr_p1 <= ZERO_ADDR;
            w_data_p1 <= ZERO_WORD;
        end else if (rdy) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                w_addr_p1 <= sel_addr_p0;
                w_data_p1 <= sel_data_p0;
            end
        end
    end

    assign wb.w_enable = vld_p1;
    assign wb.w_addr   = w_addr_p1;
    assign wb.w_data   = w_data_p1;
    assign wb.busy     = (|full) | vld_p1;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and sequencer for the register file's single write port. Up to NUM_REQ write-back sources (ALU, LSU, CSR/misc) each hand over results through a valid/ready handshake into a private one-entry slot. Each cycle the arbiter picks one full slot and drives it onto registered w_enable/w_addr/w_data outputs, which connect directly to the register file write port.

## Interface
- NUM_REQ, 3, number of write-back requesters (2..8)
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; low freezes all state
- req_valid  in  NUM_REQ  requester i offers a write
- req_ready  out  NUM_REQ  slot i accepts this cycle (combinational)
- req_addr  in  NUM_REQ*5  destination register, requester i at bits [5i+4:5i]
- req_data  in  NUM_REQ*32  write data, requester i at bits [32i+31:32i]
- w_enable  out  1  register file write enable (registered)
- w_addr  out  5  register file write address (registered)
- w_data  out  32  register file write data (registered)
- busy  out  1  any slot full or w_enable high

## Operation
- Per requester: one-entry slot {full, addr, data}.
- Acceptance: req_ready[i] = rdy & ~rst & (~full[i] | grant[i]). A slot may refill in the same cycle it drains. A transfer occurs when req_valid[i] & req_ready[i]; the slot captures addr and data.
- Arbitration: among full slots, exactly one grant per cycle when rdy=1. The granted slot clears at the clock edge unless it is refilled at the same edge.
- Output stage: on a grant, w_enable<=1, w_addr<=slot addr, w_data<=slot data. With no grant, w_enable<=0 and w_addr/w_data hold their previous values.
- x0 destinations: accepted and granted normally. The register file discards them. No special case here.
- Ordering: per-requester order is preserved. Across requesters, order is the grant order. Two writes to the same register land in grant order, so the last granted wins.
- rdy=0: no accept, no grant, and slots, pointer and outputs all hold. w_enable holds its value; the register file ignores writes while rdy is low.
- busy = |full | w_enable.

## Timing
- Reset (rst=1 at posedge): all full=0, rr pointer=0, w_enable=0, w_addr=5'h0, w_data=32'h0. req_ready=0 while rst=1.
- Latency: accept at edge t, grant in cycle t+1, w_* valid in cycle t+2. The register file commits at the end of cycle t+2 and forwards w_data to readers during t+2.
- Throughput: one write per cycle sustained. Each requester can sustain one write per cycle only while it is granted every cycle.
- Reset mid-operation: pending slot contents are discarded with no write issued. A w_enable already high is cleared at the reset edge.
- All NUM_REQ valid with empty slots: all are accepted in one cycle, then drain over NUM_REQ cycles.

## Configuration
- WB_ARB_RR_EN defined: round-robin arbitration. Pointer p names the highest-priority slot. Search order is p, p+1, …, wrapping mod NUM_REQ. After granting slot g, p<=(g+1) mod NUM_REQ. p does not change when there is no grant or when rdy=0.
- WB_ARB_RR_EN undefined: fixed priority, lowest index wins. The pointer register is absent. Starvation of high indices is permitted.

## Structure
- Shared header config.v: `RegBus, `RegAddrBus, `ZeroWord, `Enable/`Disable. Add `WbReqMax (8) there.
- Sub-module wb_slot: one-entry buffer with push, pop, full, addr and data. Instantiate it NUM_REQ times. Arbitration and the output register stay in wb_arbiter.

## Test plan
- Reset: drive rst=1 for 2 cycles with all req_valid=1. Required: req_ready=0, w_enable=0, w_addr=0, w_data=0, busy=0.
- Single write: req0 offers addr=5, data=32'hDEADBEEF at edge t. Required: w_enable=1, w_addr=5, w_data=32'hDEADBEEF only in cycle t+2, then w_enable=0.
- Contention with WB_ARB_RR_EN: all three requesters valid every cycle, data=i. Required: grants cycle 0,1,2,0,1,2…, one write per cycle, never two in one cycle.
- Fixed priority (macro off), same stimulus: required: every write comes from requester 0; req_ready[1] and req_ready[2] stay 0 after their first fill.
- Stall: assert rdy=0 for 3 cycles while slots 1 and 2 are full and w_enable=1. Required: slots, pointer and w_* unchanged, req_ready=0. After rdy=1 is restored, the writes resume in the same order.
- Same register: req1 writes x7=1 and req2 writes x7=2 in the same cycle under RR with p=1. Required: x7 written with 1, then 2 on the next cycle. A mid-drain rst drops the second write.
